dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter N_CORES, default 4, number of processor requesters sharing one data memory.
REQ-002 Parameter ADDR_W, default 12, data-memory address width.
REQ-003 Parameter DATA_W, default 12, data-memory word width.
REQ-004 Parameter RD_LAT, default 1, data-memory read latency in cycles (1..7).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rstn  in  1  async active-low reset.
REQ-006 req  in  N_CORES  per-core access request, held until ack.
REQ-007 we  in  N_CORES  per-core write flag (1=write, 0=read), valid with req.
REQ-008 addr  in  N_CORES*ADDR_W  per-core address, core i at bits [i*ADDR_W +: ADDR_W].
REQ-009 wdata  in  N_CORES*DATA_W  per-core write data, same packing.
REQ-010 ack  out  N_CORES  one-cycle completion pulse to the served core.
REQ-011 rdata  out  DATA_W  read data, valid while the served core's ack is high.
REQ-012 busy  out  1  high whenever the FSM is not IDLE.
REQ-013 mem_en, mem_we  out  1 each  data-memory enable and write strobe.
REQ-014 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  data-memory address and write data.
REQ-015 mem_rdata  in  DATA_W  data-memory read data, valid RD_LAT cycles after mem_en with mem_we=0.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, WAIT, DONE; all outputs registered.
REQ-017 IDLE: if any req bit high, select winner by round-robin starting at pointer ptr, latch winner index, we, addr, wdata; go ACCESS. Else stay IDLE.
REQ-018 Round-robin: winner = first requesting index at or above ptr, wrapping from N_CORES-1 to 0; after DONE, ptr = (winner+1) mod N_CORES.
REQ-019 ACCESS: mem_en=1 for exactly one cycle with latched mem_we, mem_addr, mem_wdata; write -> DONE; read -> WAIT.
REQ-020 WAIT: count RD_LAT cycles; capture mem_rdata into rdata on the last WAIT cycle; go DONE.
REQ-021 DONE: ack[winner]=1 for exactly one cycle, all other ack bits 0; next state IDLE.
REQ-022 Latency from req sampled in IDLE: write ack 2 cycles later; read ack RD_LAT+2 cycles later.
REQ-023 Outside ACCESS, mem_en and mem_we SHALL be 0; mem_addr/mem_wdata hold last value.
REQ-024 rdata SHALL hold its value until the next read capture; on write completion rdata is unchanged.
REQ-025 A requester dropping req after IDLE sampling SHALL not abort the transaction; ack still pulses.
REQ-026 Requester changes to addr/we/wdata after IDLE sampling SHALL have no effect on the transaction.
REQ-027 A req still high in the cycle after DONE SHALL be treated as a new request.
REQ-028 At most one transaction outstanding; requests arriving during ACCESS/WAIT/DONE wait for IDLE.

Reset
REQ-029 rstn low SHALL immediately force state IDLE, ptr=0, ack=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset mid-transaction SHALL discard it with no ack; first arbitration after release starts at core 0.

Structure
REQ-031 Package dmem_arb_pkg SHALL hold the state encoding and RD_LAT counter width constant.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs req, ptr; outputs valid, index).

Verification
REQ-033 Single write: core 2 req, we=1, addr=0x010, wdata=0x0AB -> mem_en/mem_we one cycle, mem_addr=0x010, mem_wdata=0x0AB; ack[2] 2 cycles after req.
REQ-034 Single read, RD_LAT=1: memory returns 0x5C3 at 0x020 -> ack[0] 3 cycles after req with rdata=0x5C3.
REQ-035 All four cores request continuously from reset -> service order 0,1,2,3,0; no core starved; ack one-hot.
REQ-036 Cores 1 and 3 request, ptr=2 -> core 3 served first, then core 1.
REQ-037 rstn pulsed low during WAIT -> no ack, all outputs 0, next request of core 1 served normally.
REQ-038 Core drops req and changes addr in ACCESS -> memory access uses original addr; ack still pulses.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, wait-counter
// width and an index-width helper.
package dmem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Wide enough for read latencies of 1..7 cycles.
  localparam int unsigned LAT_CNT_W = 3;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory bus of the arbiter; 'master' is the arbiter side,
// 'slave' is the side of the requesters and the memory.
interface dmem_arbiter_if #(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 12
);
  logic [N_CORES-1:0]        req;
  logic [N_CORES-1:0]        we;
  logic [N_CORES*ADDR_W-1:0] addr;
  logic [N_CORES*DATA_W-1:0] wdata;
  logic [N_CORES-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  modport master (
    input  req, we, addr, wdata, mem_rdata,
    output ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req, we, addr, wdata, mem_rdata,
    input  ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin selector: first requesting index at or above ptr,
// wrapping from the highest index back to zero.
module rr_picker
  import dmem_arb_pkg::*;
#(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned IDX_W   = idx_width(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  logic        found;
  int unsigned cand;

  always_comb begin
    found = 1'b0;
    cand  = 0;
    index = '0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_CORES) cand = cand - N_CORES;
      if (!found && req[IDX_W'(cand)]) begin
        found = 1'b1;
        index = IDX_W'(cand);
      end
    end
    valid = found;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving N_CORES requesters one-at-a-time access to a
// single data memory with a fixed read latency; all outputs are registered.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic            clk,
  input  logic            rstn,
  dmem_arbiter_if.master  bus
);

  localparam int unsigned IDX_W = idx_width(N_CORES);

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     winner_q, winner_d;
  logic                 we_q, we_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CORES-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 busy_q, busy_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;

  rr_picker #(
    .N_CORES (N_CORES),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_we    = bus.we[i];
        sel_addr  = bus.addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Outputs are computed for the state being entered so that registering them
  // lines up with the state register (mem_en in ACCESS, ack in DONE).
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    winner_d    = winner_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_ACCESS;
          winner_d    = pick_idx;
          we_d        = sel_we;
          mem_en_d    = 1'b1;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d         = ST_DONE;
          ack_d[winner_q] = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = LAT_CNT_W'(RD_LAT - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d         = ST_DONE;
          rdata_d         = bus.mem_rdata;
          ack_d[winner_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = (winner_q == IDX_W'(N_CORES - 1)) ? '0 : winner_q + IDX_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      winner_q    <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a transaction-level reference model
// compared against the DUT outputs on every cycle.
module tb_dmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam int RL = 1;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int   cyc;

  dmem_arbiter_if #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(
    .N_CORES (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RD_LAT  (RL)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pre(input int a);
    return DW'((a * 5 + 7) & 12'hFFF);
  endfunction

  // Environment memory answering the DUT, and the model's own copy.
  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];

  initial begin
    for (int a = 0; a < 4096; a++) begin
      mem[a]     = pre(a);
      ref_mem[a] = pre(a);
    end
    mem[12'h020]     = 12'h5C3;
    ref_mem[12'h020] = 12'h5C3;
  end

  always @(posedge clk) begin
    bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 12'hEEE;
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a transaction starts on the edge that samples a request;
  // everything else follows from the offset d of the current edge from it.
  bit            m_active;
  int            m_start, m_len, m_core, m_ptr;
  bit            m_we;
  logic [AW-1:0] m_addr, m_mem_addr;
  logic [DW-1:0] m_rdata, m_mem_wdata;
  int            ack_cnt, en_cnt;

  task automatic model_clear();
    m_active    = 0;
    m_ptr       = 0;
    m_rdata     = '0;
    m_mem_addr  = '0;
    m_mem_wdata = '0;
  endtask

  initial begin
    cyc = 0;
    ack_cnt = 0;
    en_cnt = 0;
    model_clear();
  end

  always @(posedge clk) begin
    int d;
    bit found;
    cyc++;
    if (!rstn) begin
      model_clear();
    end else if (m_active) begin
      d = cyc - m_start;
      if (d == m_len && !m_we) m_rdata = ref_mem[m_addr];
      if (d == m_len + 1) begin
        m_active = 0;
        m_ptr    = (m_core + 1) % N;
      end
    end else if (bus.req != '0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!found && bus.req[idx]) begin
          found       = 1;
          m_core      = idx;
          m_we        = bus.we[idx];
          m_addr      = bus.addr[idx*AW +: AW];
          m_mem_addr  = m_addr;
          m_mem_wdata = bus.wdata[idx*DW +: DW];
        end
      end
      m_active = 1;
      m_start  = cyc;
      m_len    = m_we ? 1 : RL + 1;
      if (m_we) ref_mem[m_addr] = m_mem_wdata;
    end
  end

  always @(negedge clk) begin
    int d;
    logic [N-1:0] e_ack;
    if (!rstn) model_clear();
    d     = cyc - m_start;
    e_ack = (m_active && d == m_len) ? N'(1 << m_core) : '0;
    chk("ack",       bus.ack,       e_ack);
    chk("busy",      bus.busy,      m_active);
    chk("mem_en",    bus.mem_en,    m_active && d == 0);
    chk("mem_we",    bus.mem_we,    m_active && d == 0 && m_we);
    chk("mem_addr",  bus.mem_addr,  m_mem_addr);
    chk("mem_wdata", bus.mem_wdata, m_mem_wdata);
    chk("rdata",     bus.rdata,     m_rdata);
    if (bus.ack != '0) ack_cnt++;
    if (bus.mem_en) en_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic set_core(input int i, input bit r, input bit w,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bus.req[i]            = r;
    bus.we[i]             = w;
    bus.addr[i*AW +: AW]  = a;
    bus.wdata[i*DW +: DW] = wd;
  endtask

  task automatic wait_ack(input string name, output int at);
    at = -1;
    for (int i = 0; i < 30 && at < 0; i++) begin
      tick(1);
      if (bus.ack != '0) at = cyc;
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ack expected ack within 30 cycles", name);
    end
  endtask

  function automatic int ack_index(input logic [N-1:0] a);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) if (a[k]) r = k;
    return r;
  endfunction

  initial begin
    int c, at, n, e0, ac0;
    int order [0:4];
    int exp_d [0:4];
    int got_c [0:1];
    exp_d = '{0, 1, 2, 3, 0};

    rstn      = 1'b0;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    tick(3);
    chk("rst_busy",  bus.busy,     0);
    chk("rst_ack",   bus.ack,      0);
    chk("rst_memen", bus.mem_en,   0);
    chk("rst_rdata", bus.rdata,    0);
    rstn = 1'b1;

    // Single read from core 0.
    c = cyc;
    set_core(0, 1, 0, 12'h020, 12'h000);
    wait_ack("B", at);
    chk("B_lat",   at - c,    3);
    chk("B_ack",   bus.ack,   4'b0001);
    chk("B_rdata", bus.rdata, 12'h5C3);
    set_core(0, 0, 0, 12'h000, 12'h000);
    tick(2);

    // Single write from core 2; rdata must keep the previous read value.
    e0 = en_cnt;
    c  = cyc;
    set_core(2, 1, 1, 12'h010, 12'h0AB);
    wait_ack("A", at);
    chk("A_lat",        at - c,        2);
    chk("A_ack",        bus.ack,       4'b0100);
    chk("A_rdata_hold", bus.rdata,     12'h5C3);
    chk("A_en_pulses",  en_cnt - e0,   1);
    chk("A_mem",        mem[12'h010],  12'h0AB);
    set_core(2, 0, 0, 12'h000, 12'h000);
    tick(2);

    // Core 1 write moves the pointer to 2, then cores 1 and 3 compete.
    set_core(1, 1, 1, 12'h050, 12'h0F0);
    wait_ack("C0", at);
    set_core(1, 0, 0, 12'h000, 12'h000);
    tick(2);
    set_core(1, 1, 0, 12'h010, 12'h000);
    set_core(3, 1, 0, 12'h020, 12'h000);
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      tick(1);
      if (bus.ack != '0) begin
        got_c[n] = ack_index(bus.ack);
        bus.req[got_c[n]] = 1'b0;
        n++;
      end
    end
    chk("C_count", n,        2);
    chk("C_first", got_c[0], 3);
    chk("C_second", got_c[1], 1);
    tick(2);

    // All cores request continuously straight out of reset.
    rstn = 1'b0;
    set_core(0, 1, 0, 12'h020, 12'h000);
    set_core(1, 1, 1, 12'h030, 12'h111);
    set_core(2, 1, 0, 12'h030, 12'h000);
    set_core(3, 1, 1, 12'h040, 12'h222);
    tick(2);
    rstn = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 5; i++) begin
      tick(1);
      if (bus.ack != '0) begin
        chk("D_onehot", $onehot(bus.ack), 1);
        order[n] = ack_index(bus.ack);
        n++;
      end
    end
    bus.req = '0;
    chk("D_count", n, 5);
    for (int k = 0; k < 5; k++) chk("D_order", order[k], exp_d[k]);
    tick(2);

    // Reset while core 2's read is waiting on memory.
    ac0 = ack_cnt;
    set_core(2, 1, 0, 12'h040, 12'h000);
    tick(2);
    rstn = 1'b0;
    bus.req = '0;
    tick(1);
    chk("E_busy",  bus.busy,     0);
    chk("E_ack",   bus.ack,      0);
    chk("E_addr",  bus.mem_addr, 0);
    chk("E_rdata", bus.rdata,    0);
    tick(1);
    rstn = 1'b1;
    tick(2);
    chk("E_no_ack", ack_cnt - ac0, 0);
    c = cyc;
    set_core(1, 1, 0, 12'h030, 12'h000);
    wait_ack("E", at);
    chk("E_lat",    at - c,    3);
    chk("E_ack1",   bus.ack,   4'b0010);
    chk("E_rdata1", bus.rdata, 12'h111);
    set_core(1, 0, 0, 12'h000, 12'h000);
    tick(2);

    // Core 3 changes its request fields after being sampled.
    c = cyc;
    set_core(3, 1, 1, 12'h100, 12'h123);
    tick(1);
    set_core(3, 0, 0, 12'h200, 12'h456);
    wait_ack("F", at);
    chk("F_lat",     at - c,       2);
    chk("F_ack",     bus.ack,      4'b1000);
    chk("F_mem_old", mem[12'h100], 12'h123);
    chk("F_mem_new", mem[12'h200], pre(12'h200));
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
